// File: rtl/regs_wport_ctrl_pkg.sv
// Shared widths, constants and arbiter state encoding for the regfile write-port controller.
// Optional feature macro: REGS_ARB_FAIR_EN (bounded MCU starvation).
package regs_wport_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_REGS   = 32;
  localparam int STARVE_LIM = 8;
  localparam int CNT_W      = $clog2(STARVE_LIM);

  localparam logic [ADDR_W-1:0] ZERO_REG     = '0;
  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic              WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regs_wport_ctrl_scoreboard.sv
// Busy bitmap for destinations of in-flight MCU ops: one set port, one clear port, three read ports.
// Used by regs_wport_ctrl (macro REGS_ARB_FAIR_EN does not affect this block).
module regs_wport_ctrl_scoreboard
  import regs_wport_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c
);

  logic [NUM_REGS-1:0] busy;

  // The set is written after the clear so a same-edge issue keeps the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  assign busy_a = (rd_addr_a != ZERO_REG) && busy[rd_addr_a];
  assign busy_b = (rd_addr_b != ZERO_REG) && busy[rd_addr_b];
  assign busy_c = (rd_addr_c != ZERO_REG) && busy[rd_addr_c];

  // Re-issuing to a busy register is only legal when that register is released on the same edge.
  issue_to_busy: assert property (@(posedge clk) disable iff (rst)
    (set_en && busy[set_addr]) |-> (clr_en && clr_addr == set_addr));

endmodule

// File: rtl/regs_wport_ctrl.sv
// Regfile write-port arbiter (WB over MCU) with registered write outputs and MCU hazard scoreboard.
// Define REGS_ARB_FAIR_EN to bound MCU starvation by freezing the pipe (FORCE state).
module regs_wport_ctrl
  import regs_wport_ctrl_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              arst,
  input  logic              wb_ena_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              mc_issue_i,
  input  logic [ADDR_W-1:0] mc_issue_addr_i,
  input  logic              mc_valid_i,
  input  logic [ADDR_W-1:0] mc_addr_i,
  input  logic [DATA_W-1:0] mc_data_i,
  output logic              mc_ready_o,
  input  logic [ADDR_W-1:0] id_rs1_addr_i,
  input  logic [ADDR_W-1:0] id_rs2_addr_i,
  input  logic [ADDR_W-1:0] id_rd_addr_i,
  output logic              id_stall_o,
  output logic              stall_pipe_o,
  output logic              w_ena_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o
);

  arb_state_e state, state_nxt;
  logic       xfer;
  logic       busy_rs1, busy_rs2, busy_rd;

  assign mc_ready_o = mc_valid_i & ~wb_ena_i;
  assign xfer       = mc_valid_i & mc_ready_o;

  // Writes to x0 still consume the grant but never reach the regfile.
  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      w_ena_o  <= 1'b0;
      w_addr_o <= ZERO_REG;
      w_data_o <= ZERO_WORD;
    end else if (wb_ena_i) begin
      w_ena_o  <= (wb_addr_i != ZERO_REG) ? WRITE_ENABLE : 1'b0;
      w_addr_o <= wb_addr_i;
      w_data_o <= wb_data_i;
    end else if (xfer) begin
      w_ena_o  <= (mc_addr_i != ZERO_REG) ? WRITE_ENABLE : 1'b0;
      w_addr_o <= mc_addr_i;
      w_data_o <= mc_data_i;
    end else begin
      w_ena_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

`ifdef REGS_ARB_FAIR_EN
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst)               starve_cnt <= '0;
    else if (xfer)          starve_cnt <= '0;
    else if (state == PEND) starve_cnt <= starve_cnt + 1'b1;
  end

  assign stall_pipe_o = (state == FORCE);
`else
  assign stall_pipe_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mc_valid_i && !mc_ready_o) state_nxt = PEND;
      end
      PEND: begin
        if (xfer) state_nxt = IDLE;
`ifdef REGS_ARB_FAIR_EN
        else if (starve_cnt == CNT_W'(STARVE_LIM - 1)) state_nxt = FORCE;
`endif
      end
      FORCE: begin
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  regs_wport_ctrl_scoreboard u_scoreboard (
    .clk       (clk_100MHz),
    .rst       (arst),
    .set_en    (mc_issue_i && (mc_issue_addr_i != ZERO_REG)),
    .set_addr  (mc_issue_addr_i),
    .clr_en    (xfer && (mc_addr_i != ZERO_REG)),
    .clr_addr  (mc_addr_i),
    .rd_addr_a (id_rs1_addr_i),
    .rd_addr_b (id_rs2_addr_i),
    .rd_addr_c (id_rd_addr_i),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .busy_c    (busy_rd)
  );

  assign id_stall_o = busy_rs1 | busy_rs2 | busy_rd;

endmodule
